// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer in front of a single UART TX core.
// Each grant moves one byte into a local frame register. The FSM launches
// that byte, follows tx_busy until the frame ends, then holds an idle gap
// before the next arbitration.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int LAUNCH_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_par_en,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       tx_par_en,
  output logic                       tx_data_valid,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done,
  output logic                       err_timeout
);
  localparam int IDW   = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [2:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_par_en;
  logic             r_tx_data_valid;
  logic             r_frame_done;
  logic             r_err_timeout;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_ptr_next;
  int               w_idx;

  // Winner search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && req_valid[IDW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = IDW'(w_idx);
      end
    end
  end

  assign w_ptr_next = (int'(w_win) + 1 >= NUM_REQ) ? '0 : w_win + 1'b1;

  // Accept pulse exists only in GRANT, so a withdrawn request never sees one.
  always_comb begin
    req_ready = '0;
    if (r_state == S_GRANT && w_any) req_ready[w_win] = 1'b1;
  end

  // Frame sequencer: grant, launch with timeout, wait for busy low, gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_grant_id      <= '0;
      r_tx_data       <= '0;
      r_tx_par_en     <= 1'b0;
      r_tx_data_valid <= 1'b0;
      r_frame_done    <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_gap_cnt       <= '0;
      r_to_cnt        <= '0;
    end else begin
      r_frame_done  <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) r_state <= S_GRANT;
        end
        S_GRANT: begin
          if (w_any) begin
            r_tx_data       <= req_data[w_win*WIDTH +: WIDTH];
            r_tx_par_en     <= req_par_en[w_win];
            r_grant_id      <= w_win;
            r_ptr           <= w_ptr_next;
            r_tx_data_valid <= 1'b1;
            r_to_cnt        <= '0;
            r_state         <= S_LAUNCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          if (tx_busy) begin
            r_tx_data_valid <= 1'b0;
            r_state         <= S_WAIT;
          end else begin
            // Saturating count; the exit below fires before it could wrap.
            if (r_to_cnt != TO_W'(LAUNCH_TIMEOUT)) r_to_cnt <= r_to_cnt + 1'b1;
            if (int'(r_to_cnt) + 1 >= LAUNCH_TIMEOUT) begin
              r_err_timeout   <= 1'b1;
              r_tx_data_valid <= 1'b0;
              r_gap_cnt       <= '0;
              r_state         <= S_GAP;
            end
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            r_frame_done <= 1'b1;
            r_gap_cnt    <= '0;
            r_state      <= S_GAP;
          end
        end
        S_GAP: begin
          // A zero-length gap still spends the one GAP cycle.
          if (int'(r_gap_cnt) + 1 >= GAP_CYCLES) r_state <= S_IDLE;
          else                                   r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: begin
          r_tx_data_valid <= 1'b0;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_par_en     = r_tx_par_en;
  assign tx_data_valid = r_tx_data_valid;
  assign grant_id      = r_grant_id;
  assign frame_done    = r_frame_done;
  assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. The stimulus side drives requesters and a TX
// core model, and queues the expected grants and frame endings. The monitor
// checks DUT outputs against those queues on every falling edge.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 2;
  localparam int LTO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_par_en;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_par_en;
  logic           tx_data_valid;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           frame_done;
  logic           err_timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(GAP), .LAUNCH_TIMEOUT(LTO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_ready(req_ready), .tx_data(tx_data),
    .tx_par_en(tx_par_en), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
    .grant_id(grant_id), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [W-1:0] data; logic par; } grant_t;
  grant_t exp_grant[$];
  int     exp_evt[$];   // 0 = frame_done expected, 1 = err_timeout expected
  int     checks = 0;
  int     failures = 0;
  int     model_last = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round robin: search starts just after the last winner (requester 0 after reset).
  function automatic int model_pick(input logic [N-1:0] pat, input int last);
    int start;
    int idx;
    start = (last + 1) % N;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (pat[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic check_zeros();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_par_en", tx_par_en, 0);
    chk("rst_tx_data_valid", tx_data_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_timeout", err_timeout, 0);
  endtask

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           g_cyc = 0;
  int           fall_cyc = -10;
  logic         prev_tdv = 1'b0;
  logic         prev_busy = 1'b0;
  grant_t       cur;
  grant_t       e;
  int           ev;
  logic [N-1:0] oh;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_tdv  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (req_ready != '0) begin
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", req_ready, 0);
        end else begin
          e = exp_grant.pop_front();
          oh = '0;
          oh[2'(e.idx)] = 1'b1;
          chk("grant_onehot", req_ready, oh);
          cur   = e;
          g_cyc = cyc;
        end
      end
      if (tx_data_valid && !prev_tdv) begin
        chk("launch_latency", cyc, g_cyc + 1);
        chk("launch_data", tx_data, cur.data);
        chk("launch_par", tx_par_en, cur.par);
        chk("launch_grant_id", grant_id, cur.idx);
      end
      if (frame_done || err_timeout) begin
        if (exp_evt.size() == 0) begin
          chk("unexpected_end", {frame_done, err_timeout}, 0);
        end else begin
          ev = exp_evt.pop_front();
          chk("end_kind_done", frame_done, ev == 0);
          chk("end_kind_timeout", err_timeout, ev == 1);
          if (frame_done) chk("done_latency", cyc, fall_cyc + 1);
          chk("end_data_hold", tx_data, cur.data);
          chk("end_par_hold", tx_par_en, cur.par);
        end
      end
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      prev_tdv  = tx_data_valid;
      prev_busy = tx_busy;
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: normal frame, 1: TX core never goes busy, 2: reset in WAIT_DONE.
  // d: LAUNCH cycles before busy rises (-1 = busy already high on entry).
  // exp_wait: expected falling edges from req_valid set to req_ready (0 = skip).
  task automatic do_frame(input logic [N-1:0] pat, input logic [N*W-1:0] dat,
                          input logic [N-1:0] par, input int mode, input int d,
                          input int blen, input int exp_wait);
    int  win;
    int  n;
    bit  seen;
    grant_t g;
    win = model_pick(pat, model_last);
    g.idx  = win;
    g.data = dat[win*W +: W];
    g.par  = par[win];
    exp_grant.push_back(g);
    req_data   = dat;
    req_par_en = par;
    req_valid  = pat;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) seen = 1;
    end
    chk("grant_seen", seen, 1);
    if (!seen) begin
      void'(exp_grant.pop_back());
      req_valid = '0;
      @(posedge clk); #1;
      return;
    end
    if (exp_wait > 0) chk("grant_wait", n, exp_wait);
    model_last = win;
    if (d < 0 && mode != 1) tx_busy = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    if (mode == 1) begin
      exp_evt.push_back(1);
      seen = 0;
      n = 0;
      for (int c = 0; c < LTO + 10 && !seen; c++) begin
        @(negedge clk);
        if (err_timeout) seen = 1;
        else if (tx_data_valid) n++;
      end
      chk("timeout_seen", seen, 1);
      chk("timeout_len", n, LTO);
      chk("timeout_tdv_low", tx_data_valid, 0);
      @(posedge clk); #1;
      return;
    end
    if (d > 0) repeat (d) begin @(posedge clk); #1; end
    tx_busy = 1'b1;
    @(negedge clk);
    chk("launch_hold", tx_data_valid, 1);
    @(posedge clk);
    @(negedge clk);
    chk("launch_drop", tx_data_valid, 0);
    if (mode == 2) begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      tx_busy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_zeros();
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = -1;
      return;
    end
    repeat (blen) @(posedge clk);
    #1;
    exp_evt.push_back(0);
    tx_busy = 1'b0;
  endtask

  function automatic logic [N*W-1:0] rand_dat();
    logic [N*W-1:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] dat;
    int             kind;
    int             mode;
    int             d;
    req_valid  = '0;
    req_data   = '0;
    req_par_en = '0;
    tx_busy    = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zeros();
    @(posedge clk); #1;
    rst = 1'b0;

    // single requester 1, byte A5 with parity
    dat = rand_dat();
    dat[1*W +: W] = 8'hA5;
    do_frame(4'b0010, dat, 4'b0010, 0, 1, 11, 2);
    repeat (GAP + 3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = -1;

    // all four held: 0,1,2,3 then 0 and 2 from {0,2}
    dat = {8'h13, 8'h12, 8'h11, 8'h10};
    do_frame(4'b1111, dat, 4'b0101, 0, 0, 11, 2);
    do_frame(4'b1111, dat, 4'b0101, 0, 2, 11, GAP + 3);
    do_frame(4'b1111, dat, 4'b0101, 0, -1, 11, GAP + 3);
    do_frame(4'b1111, dat, 4'b0101, 0, 3, 11, GAP + 3);
    do_frame(4'b0101, rand_dat(), 4'($urandom), 0, 0, 5, GAP + 3);
    do_frame(4'b0101, rand_dat(), 4'($urandom), 0, 1, 5, GAP + 3);

    // launch timeout, then a normal frame right behind it
    do_frame(4'($urandom_range(1, 15)), rand_dat(), 4'($urandom), 1, 0, 0, GAP + 3);
    do_frame(4'($urandom_range(1, 15)), rand_dat(), 4'($urandom), 0, 0, 4, GAP + 1);

    // reset in WAIT_DONE after a grant to 1
    do_frame(4'b0010, rand_dat(), 4'b1111, 2, 0, 0, GAP + 3);

    // request withdrawn before GRANT
    req_valid = 4'b1001;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) begin
      @(negedge clk);
      chk("withdraw_tdv", tx_data_valid, 0);
      chk("withdraw_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    do_frame(4'b1001, rand_dat(), 4'($urandom), 0, 0, 3, 2);

    kind = 0;
    for (int i = 0; i < 25; i++) begin
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      d = $urandom_range(0, 4);
      if (d == 4) d = -1;
      do_frame(4'($urandom_range(1, 15)), rand_dat(), 4'($urandom), mode, d,
               $urandom_range(1, 12), (kind == 0) ? GAP + 3 : GAP + 1);
      kind = mode;
    end

    repeat (10) @(posedge clk);
    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("event_queue_empty", exp_evt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
